dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory (combinational read, synchronous write, word-addressed by `addr[31:2]`) between the processor's load/store port and a secondary master (loader/debug/DMA). Sits between the CPU and `data_mem` in the top level. It grants at most one requester per cycle with zero added latency, and bounds the waiting time of both requesters. Port 1 gets burst locking and starvation protection.

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data memory (combinational read, synchronous write) between the
//   CPU load/store port (port 0) and a secondary master (port 1). At most one
//   port is granted per cycle, and the grant is combinational, so it adds no
//   latency. Port 1 can lock the memory for a burst of up to MAX_BURST beats.
//   Port 1 cannot wait more than MAX_WAIT cycles while port 0 keeps requesting.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req0_*                port 0: valid/we/addr/wdata in, ready/rdata out
//   req1_*                port 1: same as port 0, plus req1_last (final beat)
//   mem_we/addr/wdata     to data_mem
//   mem_rdata             from data_mem (passed to both ports unchanged)
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_last,
  output logic          req1_ready,
  output logic [DW-1:0] req1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {ARB = 1'b0, LOCK1 = 1'b1} state_t;

  localparam logic [3:0] WAIT_LIM   = 4'(MAX_WAIT);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam bit         BURST_EN   = (MAX_BURST > 1);

  state_t     state, state_n;
  logic [3:0] wait1, wait1_n;
  logic [7:0] beats, beats_n;
  logic       grant0, grant1;

  function automatic logic [3:0] wait_sat_inc(input logic [3:0] w);
    return (w >= WAIT_LIM) ? WAIT_LIM : w + 4'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB;
      wait1 <= 4'd0;
      beats <= 8'd0;
    end else begin
      state <= state_n;
      wait1 <= wait1_n;
      beats <= beats_n;
    end
  end

  // Grant and memory mux. Reset masks both grants, so no write can
  // reach the memory while reset is high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (state == LOCK1) grant1 = req1_valid;
      else                grant1 = req1_valid && (!req0_valid || wait1 == WAIT_LIM);
      grant0 = req0_valid && !grant1;
    end
    req0_ready = grant0;
    req1_ready = grant1;
    mem_addr   = grant1 ? req1_addr  : req0_addr;
    mem_wdata  = grant1 ? req1_wdata : req0_wdata;
    mem_we     = grant1 ? req1_we : (grant0 ? req0_we : 1'b0);
    req0_rdata = mem_rdata;
    req1_rdata = mem_rdata;
  end

  // Next-state: starvation counter and burst lock.
  always_comb begin
    state_n = state;
    beats_n = beats;
    wait1_n = wait1;
    if (!req1_valid || grant1) wait1_n = 4'd0;
    else                       wait1_n = wait_sat_inc(wait1);
    case (state)
      ARB: begin
        if (grant1 && !req1_last && BURST_EN) begin
          state_n = LOCK1;
          beats_n = 8'd1;
        end
      end
      LOCK1: begin
        if (!req1_valid) begin
          state_n = ARB;
          beats_n = 8'd0;
        end else if (req1_last || beats == BURST_LAST) begin
          // Forced release at MAX_BURST beats lets port 0 in next cycle.
          state_n = ARB;
          beats_n = 8'd0;
        end else begin
          beats_n = beats + 8'd1;
        end
      end
      default: begin
        state_n = ARB;
        beats_n = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic        req0_ready;
  logic [31:0] req0_rdata;
  logic        req1_valid = 1'b0, req1_we = 1'b0, req1_last = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic        req1_ready;
  logic [31:0] req1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_last(req1_last), .req1_ready(req1_ready),
    .req1_rdata(req1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory behind the arbiter: 64 words, combinational read.
  logic [31:0] phys [64];
  logic        mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) phys[i] <= '0;
    end else if (mem_we) begin
      phys[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = phys[mem_addr[7:2]];

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the memory, how long port 1 has waited,
  // how many beats the current burst has taken, and what memory holds.
  bit          m_locked;
  int          m_wait, m_beats;
  logic [31:0] ref_mem [64];

  logic        obs_r0, obs_r1;
  logic [31:0] obs_rd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_grant(output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset) return;
    if (m_locked) g1 = req1_valid;
    else          g1 = req1_valid && (!req0_valid || m_wait >= MAX_WAIT);
    g0 = req0_valid && !g1;
  endtask

  task automatic model_update(input bit g0, input bit g1);
    if (reset) begin
      m_locked = 1'b0; m_wait = 0; m_beats = 0;
      return;
    end
    if (g0 && req0_we) ref_mem[req0_addr[7:2]] = req0_wdata;
    if (g1 && req1_we) ref_mem[req1_addr[7:2]] = req1_wdata;
    if (!req1_valid || g1) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
    if (g1) begin
      if (!m_locked) begin
        if (!req1_last && MAX_BURST > 1) begin m_locked = 1'b1; m_beats = 1; end
      end else begin
        m_beats = m_beats + 1;
        if (req1_last || m_beats == MAX_BURST) begin m_locked = 1'b0; m_beats = 0; end
      end
    end else if (m_locked && !req1_valid) begin
      m_locked = 1'b0; m_beats = 0;
    end
  endtask

  // One clock: inputs are already driven; check outputs mid-cycle, then
  // advance the model with the rising edge.
  task automatic step(input string tag);
    bit g0, g1;
    logic exp_we;
    #1;
    model_grant(g0, g1);
    exp_we  = g1 ? req1_we : (g0 ? req0_we : 1'b0);
    obs_r0  = req0_ready;
    obs_r1  = req1_ready;
    obs_rd0 = req0_rdata;
    chk({tag, ".rdy0"}, 32'(req0_ready), 32'(g0));
    chk({tag, ".rdy1"}, 32'(req1_ready), 32'(g1));
    chk({tag, ".we"}, 32'(mem_we), 32'(exp_we));
    chk({tag, ".addr"}, mem_addr, g1 ? req1_addr : req0_addr);
    chk({tag, ".wdata"}, mem_wdata, g1 ? req1_wdata : req0_wdata);
    if (g0) chk({tag, ".rdata0"}, req0_rdata, ref_mem[req0_addr[7:2]]);
    if (g1) chk({tag, ".rdata1"}, req1_rdata, ref_mem[req1_addr[7:2]]);
    @(posedge clk);
    model_update(g0, g1);
    #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic last);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_last = last;
  endtask

  initial begin
    logic [9:0]  pat_ct;
    logic [7:0]  pat_l1, pat_l0;
    logic [19:0] pat_f1;
    int          beat;

    m_locked = 1'b0; m_wait = 0; m_beats = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;

    // Reset with both ports requesting writes
    @(posedge clk); #1;
    set0(1, 1, 32'h10, 32'h1234_5678);
    set1(1, 1, 32'h14, 32'h8765_4321, 1);
    step("rst");
    chk("rst.r0", 32'(obs_r0), 32'd0);
    chk("rst.r1", 32'(obs_r1), 32'd0);
    mem_clr = 1'b0;
    reset   = 1'b0;

    // First cycle out of reset: port-0 read of 0x10
    set1(0, 0, 32'h0, 32'h0, 0);
    set0(1, 0, 32'h10, 32'h0);
    step("first");
    chk("first.r0", 32'(obs_r0), 32'd1);

    // Port-0 write then read-back
    set0(1, 1, 32'h20, 32'hDEAD_BEEF);
    step("p0wr");
    set0(1, 0, 32'h20, 32'h0);
    step("p0rd");
    chk("p0rd.data", obs_rd0, 32'hDEAD_BEEF);
    chk("p0rd.r1", 32'(obs_r1), 32'd0);

    // Contention with single-beat port-1 requests
    pat_ct = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      set0(1, 0, 32'(($urandom % 64) * 4), 32'h0);
      set1(1, 0, 32'(($urandom % 64) * 4), 32'h0, 1);
      step("cont");
      chk("cont.pat", 32'(obs_r1), 32'(pat_ct[i]));
    end
    set1(0, 0, 32'h0, 32'h0, 0);
    set0(0, 0, 32'h0, 32'h0);
    step("idle1");

    // Three-beat write burst against continuous port-0 traffic
    pat_l1 = 8'b0111_0000;
    pat_l0 = 8'b1000_1111;
    beat = 0;
    for (int i = 0; i < 8; i++) begin
      if (beat < 3) set1(1, 1, 32'h40 + 32'(beat * 4), 32'h5500_0000 + 32'(beat), logic'(beat == 2));
      else          set1(0, 0, 32'h0, 32'h0, 0);
      set0(1, 0, 32'h10, 32'h0);
      step("lock");
      chk("lock.r1", 32'(obs_r1), 32'(pat_l1[i]));
      chk("lock.r0", 32'(obs_r0), 32'(pat_l0[i]));
      if (obs_r1) beat++;
    end
    set0(1, 0, 32'h44, 32'h0);
    step("lockrd");
    chk("lockrd.data", obs_rd0, 32'h5500_0001);

    // Twelve-beat stream with no last: forced release after MAX_BURST
    set0(0, 0, 32'h0, 32'h0);
    step("idle2");
    pat_f1 = 20'hF0FF0;
    beat = 0;
    for (int i = 0; i < 20; i++) begin
      set1(logic'(beat < 12), 0, 32'(($urandom % 64) * 4), 32'h0, 0);
      set0(1, 0, 32'(($urandom % 64) * 4), 32'h0);
      step("frel");
      chk("frel.r1", 32'(obs_r1), 32'(pat_f1[i]));
      if (obs_r1) beat++;
    end
    chk("frel.beats", 32'(beat), 32'd12);
    set1(0, 0, 32'h0, 32'h0, 0);
    set0(0, 0, 32'h0, 32'h0);
    step("idle3");

    // Reset raised on beat 2 of a write burst
    set1(1, 1, 32'h80, 32'hA0A0_0001, 0);
    step("mb0");
    chk("mb0.r1", 32'(obs_r1), 32'd1);
    set1(1, 1, 32'h84, 32'hA0A0_0002, 0);
    #1;
    chk("mb1.we_before", 32'(mem_we), 32'd1);
    reset = 1'b1;
    step("mb1rst");
    reset = 1'b0;
    set1(0, 0, 32'h0, 32'h0, 0);
    set0(1, 0, 32'h84, 32'h0);
    step("mbrd");
    chk("mbrd.r0", 32'(obs_r0), 32'd1);
    chk("mbrd.data", obs_rd0, 32'h0);
    chk("mbrd.phys", phys[33], 32'h0);

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      reset = logic'(($urandom % 64) == 0);
      set0(logic'(($urandom % 4) != 0), logic'($urandom % 2),
           32'(($urandom % 64) * 4), $urandom);
      set1(logic'(($urandom % 3) != 0), logic'($urandom % 2),
           32'(($urandom % 64) * 4), $urandom, logic'(($urandom % 4) == 0));
      step("rand");
    end
    reset = 1'b0;
    set0(0, 0, 32'h0, 32'h0);
    set1(0, 0, 32'h0, 32'h0, 0);
    step("idle4");

    for (int i = 0; i < 64; i++) chk("memimg", phys[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
